stride_counter: RTL and testbench
=================================

Name: stride_counter

Overview:
- Parametrised stride counter, successor to the fixed 4-bit even-step counter.
- Counts in power-of-two strides between 0 and a runtime limit, in up, down, bounce or hold mode.
- Supports synchronous clear, aligned load and a registered wrap/turnaround pulse.
- Used as a sequencing and address-stride generator in datapath blocks.

Parameters:
- WIDTH, 4, counter width in bits (>= 2).
- STEP_LOG2, 1, log2 of the stride; STEP = 2**STEP_LOG2. Requires STEP_LOG2 < WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  advance enable.
- clr  in  1  synchronous clear.
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  load value; low STEP_LOG2 bits are ignored.
- mode  in  2  00 up, 01 down, 10 bounce, 11 hold.
- limit  in  WIDTH  top of range; low STEP_LOG2 bits are ignored.
- count  out  WIDTH  current count, registered.
- dir  out  1  direction, registered: 1 = up, 0 = down (meaningful in bounce mode).
- wrap  out  1  one-cycle registered pulse on wrap or turnaround.
- at_limit  out  1  combinational: count == lim_a.

Behaviour:
- Reset and clock:
  - Reset is asynchronous, active-high; clock is clk.
  - Reset values: count = 0, dir = 1, wrap = 0.
- Derived values:
  - lim_a = limit with the low STEP_LOG2 bits cleared.
  - ld_a = load_val with the low STEP_LOG2 bits cleared.
  - count is always a multiple of STEP.
- Priority per cycle: clr > load > (en and mode != 11) > hold.
  - clr: count <= 0, dir <= 1, wrap <= 0.
  - load: if ld_a <= lim_a then count <= ld_a, else count <= 0. dir unchanged, wrap <= 0.
- wrap defaults to 0 every cycle. It is 1 only in the cycle after an enabled step that wraps or turns around.
- Degenerate range (lim_a == 0), enabled: count <= 0, wrap <= 0, in every mode.
- Out-of-range (count > lim_a, e.g. limit lowered at runtime), enabled, any active mode: count <= 0, dir <= 1, wrap <= 1.
- Up (00), enabled:
  - Compute count + STEP in WIDTH+1 bits.
  - If the sum <= lim_a: count <= sum.
  - Else: count <= 0, wrap <= 1.
  - The WIDTH+1-bit sum means no silent overflow at all-ones limits.
- Down (01), enabled:
  - If count >= STEP: count <= count - STEP.
  - Else: count <= lim_a, wrap <= 1.
- Bounce (10), enabled:
  - dir = 1: if count + STEP <= lim_a, count <= count + STEP. Else count <= lim_a - STEP, dir <= 0, wrap <= 1.
  - dir = 0: if count >= STEP, count <= count - STEP. Else count <= STEP, dir <= 1, wrap <= 1.
  - When lim_a == STEP, bounce alternates 0 and STEP, pulsing wrap each step.
- Hold (11) or en = 0: all registers keep their values; wrap <= 0.
- Mode change mid-count: takes effect on the next enabled edge from the current count; no internal state besides dir.
- Latency: count updates on the edge where en is sampled high (one-cycle latency). at_limit follows count combinationally.
- Reset asserted mid-operation: immediate return to reset values, independent of clk.
- Default parameters with mode = 00 and limit = 14 reproduce the legacy even counter: 0, 2, …, 14, 0.

Test Plan:
- Up wrap (WIDTH=4, STEP_LOG2=1, limit=14, mode=00, en=1 from reset): count 0,2,4,…,14,0; wrap high only in the cycle count returns to 0; at_limit high at count=14.
- Down wrap (limit=15 so lim_a=14, load_val=5): load gives count=4. Then mode=01 steps 4,2,0,14; wrap pulses on 0→14.
- Bounce (STEP_LOG2=2, WIDTH=5, limit=12): count 0,4,8,12,8,4,0,4. wrap pulses at 12→8 and 0→4; dir toggles 1→0→1.
- Priority (clr=1, load=1, load_val=6, en=1 in the same cycle): count=0, dir=1. Next cycle load=1, en=1: count=6. Out-of-range load_val=18 with limit=14: count=0.
- Runtime limit drop (up mode, count=12, limit changed to 6): next enabled edge count=0 with wrap=1. Then 0,2,4,6,0. limit=1 (lim_a=0): count held at 0, wrap stays 0.
- Async reset (assert reset between clk edges at count=10 in bounce, dir=0): count=0, dir=1, wrap=0 immediately. Hold (mode=11) and en=0 keep count unchanged across 5 cycles.

Source files
------------

// File: rtl/stride_counter.sv
// Stride counter: steps by 2**STEP_LOG2 between 0 and an aligned runtime limit
// in up, down, bounce or hold mode, with a registered wrap/turnaround pulse.
//
// dir | meaning
// 1   | moving up (bounce); also the resting value outside bounce
// 0   | moving down (bounce)
module stride_counter #(
    parameter int WIDTH     = 4,
    parameter int STEP_LOG2 = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             wrap,
    output logic             at_limit
);
    localparam logic [1:0] MODE_UP     = 2'b00;
    localparam logic [1:0] MODE_DOWN   = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;
    localparam logic [1:0] MODE_HOLD   = 2'b11;

    localparam logic [WIDTH-1:0] STEP  = WIDTH'(1) << STEP_LOG2;
    localparam logic [WIDTH-1:0] ALIGN = ~(STEP - WIDTH'(1));

    logic [WIDTH-1:0] lim_a;
    logic [WIDTH-1:0] ld_a;
    logic [WIDTH-1:0] count_n;
    logic             dir_n;
    logic             wrap_n;
    logic [WIDTH:0]   sum_up;
    logic             fits_up;
    logic             fits_dn;

    assign lim_a   = limit & ALIGN;
    assign ld_a    = load_val & ALIGN;
    // One extra bit so count + STEP cannot alias back below an all-ones limit.
    assign sum_up  = {1'b0, count} + {1'b0, STEP};
    assign fits_up = (sum_up <= {1'b0, lim_a});
    assign fits_dn = (count >= STEP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            dir   <= 1'b1;
            wrap  <= 1'b0;
        end else begin
            count <= count_n;
            dir   <= dir_n;
            wrap  <= wrap_n;
        end
    end

    always_comb begin
        count_n = count;
        dir_n   = dir;
        wrap_n  = 1'b0;
        if (clr) begin
            count_n = '0;
            dir_n   = 1'b1;
        end else if (load) begin
            count_n = (ld_a <= lim_a) ? ld_a : '0;
        end else if (en && (mode != MODE_HOLD)) begin
            if (lim_a == '0) begin
                count_n = '0;
            end else if (count > lim_a) begin
                // Limit was lowered under the count: restart cleanly from 0.
                count_n = '0;
                dir_n   = 1'b1;
                wrap_n  = 1'b1;
            end else begin
                case (mode)
                    MODE_UP: begin
                        if (fits_up) begin
                            count_n = sum_up[WIDTH-1:0];
                        end else begin
                            count_n = '0;
                            wrap_n  = 1'b1;
                        end
                    end
                    MODE_DOWN: begin
                        if (fits_dn) begin
                            count_n = count - STEP;
                        end else begin
                            count_n = lim_a;
                            wrap_n  = 1'b1;
                        end
                    end
                    MODE_BOUNCE: begin
                        if (dir) begin
                            if (fits_up) begin
                                count_n = sum_up[WIDTH-1:0];
                            end else begin
                                count_n = lim_a - STEP;
                                dir_n   = 1'b0;
                                wrap_n  = 1'b1;
                            end
                        end else begin
                            if (fits_dn) begin
                                count_n = count - STEP;
                            end else begin
                                count_n = STEP;
                                dir_n   = 1'b1;
                                wrap_n  = 1'b1;
                            end
                        end
                    end
                    default: begin
                        count_n = count;
                    end
                endcase
            end
        end
    end

    always_comb begin
        at_limit = (count == lim_a);
    end

endmodule

// File: tb/tb_stride_counter.sv
// Directed bench for stride_counter: default instance (4-bit, step 2) driven from a
// vector table, plus a 5-bit step-4 instance for bounce and wide-load corner cases.
module tb_stride_counter;
    logic       clk;
    logic       reset;

    logic       en, clr, load;
    logic [3:0] load_val, limit, count;
    logic [1:0] mode;
    logic       dir, wrap, at_limit;

    logic       en_b, clr_b, load_b;
    logic [4:0] load_val_b, limit_b, count_b;
    logic [1:0] mode_b;
    logic       dir_b, wrap_b, at_limit_b;

    int errors = 0;
    int checks = 0;

    stride_counter dut (
        .clk(clk), .reset(reset), .en(en), .clr(clr), .load(load),
        .load_val(load_val), .mode(mode), .limit(limit),
        .count(count), .dir(dir), .wrap(wrap), .at_limit(at_limit)
    );

    stride_counter #(.WIDTH(5), .STEP_LOG2(2)) dut_b (
        .clk(clk), .reset(reset), .en(en_b), .clr(clr_b), .load(load_b),
        .load_val(load_val_b), .mode(mode_b), .limit(limit_b),
        .count(count_b), .dir(dir_b), .wrap(wrap_b), .at_limit(at_limit_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       clr;
        logic       load;
        logic [3:0] load_val;
        logic [1:0] mode;
        logic [3:0] limit;
        logic       en;
        logic [3:0] e_count;
        logic       e_dir;
        logic       e_wrap;
        logic       e_at;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic c, input logic l, input logic [3:0] lv,
                                input logic [1:0] m, input logic [3:0] lim, input logic e,
                                input logic [3:0] ec, input logic ed, input logic ew,
                                input logic ea);
        vec_t v;
        v.clr = c; v.load = l; v.load_val = lv; v.mode = m; v.limit = lim; v.en = e;
        v.e_count = ec; v.e_dir = ed; v.e_wrap = ew; v.e_at = ea;
        vecs.push_back(v);
    endfunction

    task automatic chk_a(input string nm, input logic [3:0] ec, input logic ed,
                         input logic ew, input logic ea);
        checks++;
        if (count !== ec || dir !== ed || wrap !== ew || at_limit !== ea) begin
            errors++;
            $display("FAIL %s: got count=%0d dir=%b wrap=%b at_limit=%b, expected count=%0d dir=%b wrap=%b at_limit=%b",
                     nm, count, dir, wrap, at_limit, ec, ed, ew, ea);
        end
    endtask

    task automatic chk_b(input string nm, input logic [4:0] ec, input logic ed,
                         input logic ew, input logic ea);
        checks++;
        if (count_b !== ec || dir_b !== ed || wrap_b !== ew || at_limit_b !== ea) begin
            errors++;
            $display("FAIL %s: got count=%0d dir=%b wrap=%b at_limit=%b, expected count=%0d dir=%b wrap=%b at_limit=%b",
                     nm, count_b, dir_b, wrap_b, at_limit_b, ec, ed, ew, ea);
        end
    endtask

    task automatic step_a(input logic c, input logic l, input logic [3:0] lv,
                          input logic [1:0] m, input logic [3:0] lim, input logic e,
                          input logic [3:0] ec, input logic ed, input logic ew,
                          input logic ea, input string nm);
        clr = c; load = l; load_val = lv; mode = m; limit = lim; en = e;
        @(posedge clk);
        #1;
        chk_a(nm, ec, ed, ew, ea);
    endtask

    task automatic step_b(input logic c, input logic l, input logic [4:0] lv,
                          input logic [1:0] m, input logic [4:0] lim, input logic e,
                          input logic [4:0] ec, input logic ed, input logic ew,
                          input logic ea, input string nm);
        clr_b = c; load_b = l; load_val_b = lv; mode_b = m; limit_b = lim; en_b = e;
        @(posedge clk);
        #1;
        chk_b(nm, ec, ed, ew, ea);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        en = 0; clr = 0; load = 0; load_val = 0; mode = 2'b00; limit = 4'd14;
        en_b = 0; clr_b = 0; load_b = 0; load_val_b = 0; mode_b = 2'b00; limit_b = 5'd12;

        // up wrap 0,2..14,0 with at_limit at 14
        add(0,0,0,2'b00,14,1,  2,1,0,0);
        add(0,0,0,2'b00,14,1,  4,1,0,0);
        add(0,0,0,2'b00,14,1,  6,1,0,0);
        add(0,0,0,2'b00,14,1,  8,1,0,0);
        add(0,0,0,2'b00,14,1, 10,1,0,0);
        add(0,0,0,2'b00,14,1, 12,1,0,0);
        add(0,0,0,2'b00,14,1, 14,1,0,1);
        add(0,0,0,2'b00,14,1,  0,1,1,0);
        add(0,0,0,2'b00,14,1,  2,1,0,0);
        // aligned load then down wrap 4,2,0,14
        add(0,1,5,2'b00,15,0,  4,1,0,0);
        add(0,0,0,2'b01,15,1,  2,1,0,0);
        add(0,0,0,2'b01,15,1,  0,1,0,0);
        add(0,0,0,2'b01,15,1, 14,1,1,1);
        add(0,0,0,2'b01,15,1, 12,1,0,0);
        // priority clr > load > en, then out-of-range load
        add(1,1,6,2'b01,14,1,  0,1,0,0);
        add(0,1,6,2'b00,14,1,  6,1,0,0);
        add(0,1,10,2'b00,6,1,  0,1,0,0);
        // runtime limit drop in up mode, then degenerate limit
        add(0,1,12,2'b00,14,0, 12,1,0,0);
        add(0,0,0,2'b00,6,1,   0,1,1,0);
        add(0,0,0,2'b00,6,1,   2,1,0,0);
        add(0,0,0,2'b00,6,1,   4,1,0,0);
        add(0,0,0,2'b00,6,1,   6,1,0,1);
        add(0,0,0,2'b00,6,1,   0,1,1,0);
        add(0,0,0,2'b00,1,1,   0,1,0,1);
        add(0,0,0,2'b00,1,1,   0,1,0,1);
        // out-of-range in down mode restarts at 0
        add(0,1,12,2'b01,14,0, 12,1,0,0);
        add(0,0,0,2'b01,6,1,   0,1,1,0);
        // hold mode and en=0 keep count for 5 cycles
        add(0,1,8,2'b00,14,0,  8,1,0,0);
        add(0,0,0,2'b11,14,1,  8,1,0,0);
        add(0,0,0,2'b11,14,1,  8,1,0,0);
        add(0,0,0,2'b11,14,1,  8,1,0,0);
        add(0,0,0,2'b00,14,0,  8,1,0,0);
        add(0,0,0,2'b10,14,0,  8,1,0,0);

        #7;
        chk_a("reset_a", 0, 1, 0, 0);
        chk_b("reset_b", 0, 1, 0, 0);
        #5 reset = 1'b0;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            step_a(vecs[i].clr, vecs[i].load, vecs[i].load_val, vecs[i].mode, vecs[i].limit,
                   vecs[i].en, vecs[i].e_count, vecs[i].e_dir, vecs[i].e_wrap, vecs[i].e_at,
                   $sformatf("vec[%0d]", i));
        end
        en = 0; load = 0; clr = 0;

        // dut_b still sits at reset values; bounce 0,4,8,12,8,4,0,4
        step_b(0,0,0,2'b10,12,1,  4,1,0,0, "bounce_b[0]");
        step_b(0,0,0,2'b10,12,1,  8,1,0,0, "bounce_b[1]");
        step_b(0,0,0,2'b10,12,1, 12,1,0,1, "bounce_b[2]");
        step_b(0,0,0,2'b10,12,1,  8,0,1,0, "bounce_b[3]");
        step_b(0,0,0,2'b10,12,1,  4,0,0,0, "bounce_b[4]");
        step_b(0,0,0,2'b10,12,1,  0,0,0,0, "bounce_b[5]");
        step_b(0,0,0,2'b10,12,1,  4,1,1,0, "bounce_b[6]");
        // lim_a == STEP: alternate 0 and STEP
        step_b(1,0,0,2'b10,4,1,   0,1,0,0, "narrow_b[0]");
        step_b(0,0,0,2'b10,4,1,   4,1,0,1, "narrow_b[1]");
        step_b(0,0,0,2'b10,4,1,   0,0,1,0, "narrow_b[2]");
        step_b(0,0,0,2'b10,4,1,   4,1,1,1, "narrow_b[3]");
        step_b(0,0,0,2'b10,4,1,   0,0,1,0, "narrow_b[4]");
        // load above lim_a gives 0; load keeps dir
        step_b(0,1,18,2'b00,14,1, 0,0,0,0, "load_b_oor");
        step_b(0,1,9,2'b00,14,1,  8,0,0,0, "load_b_align");
        en_b = 0; load_b = 0;

        // bounce on dut to count=10 with dir=0, then async reset between edges
        step_a(1,0,0,2'b10,14,1,  0,1,0,0, "bnc_a[0]");
        step_a(0,0,0,2'b10,14,1,  2,1,0,0, "bnc_a[1]");
        for (int k = 2; k <= 7; k++) begin
            clr = 0; mode = 2'b10; limit = 14; en = 1;
            @(posedge clk);
        end
        #1;
        chk_a("bnc_a_top", 14, 1, 0, 1);
        step_a(0,0,0,2'b10,14,1, 12,0,1,0, "bnc_a_turn");
        step_a(0,0,0,2'b10,14,1, 10,0,0,0, "bnc_a_10");
        #2 reset = 1'b1;
        #1;
        chk_a("async_reset_a", 0, 1, 0, 0);
        chk_b("async_reset_b", 0, 1, 0, 0);
        #2 reset = 1'b0;
        en = 0;
        @(posedge clk);
        #1;
        chk_a("post_reset_idle", 0, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
